sb_msg_tx_engine: RTL
=====================

SB_MSG_TX_ENGINE -- requirements
Module: sb_msg_tx_engine

Interface
REQ-001 SHALL have parameter SB_MSG_WIDTH, default 4, width of the encoded LTSM message code.
REQ-002 SHALL have parameter GAP_UI, default 32, number of idle-low UI after each packet.
REQ-003 SHALL have parameter PATTERN_ITER, default 2, number of 64-UI clock-pattern iterations per pattern request.
REQ-004 SHALL have port i_clk, input, 1, sideband UI clock; one UI per cycle.
REQ-005 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_start_pattern_req, input, 1, level request from LTSM to send the clock pattern.
REQ-007 SHALL have port i_encoded_msg, input, SB_MSG_WIDTH, LTSM message code.
REQ-008 SHALL have port i_msg_valid, input, 1, i_encoded_msg qualifier.
REQ-009 SHALL have port o_start_pattern_done, output, 1, pattern complete (level).
REQ-010 SHALL have port o_busy, output, 1, engine occupied; its falling edge marks message completion.
REQ-011 SHALL have port o_sb_data, output, 1, serial sideband data, LSB first.
REQ-012 SHALL have port o_sb_clk_en, output, 1, forwarded-clock enable, high only while o_sb_data carries pattern or packet bits.
REQ-013 SHALL have port o_err_unsupported, output, 1, one-cycle pulse on a rejected code.

Function
REQ-014 SHALL implement FSM states IDLE, PATTERN, PKT, GAP, PAT_HOLD.
REQ-015 In IDLE with i_msg_valid=1 and a supported code, SHALL latch the 64-bit packet and enter PKT next cycle; i_msg_valid SHALL have priority over i_start_pattern_req in the same cycle.
REQ-016 Supported codes SHALL map as follows: 1 -> msgcode 0x91, subcode 0x00 (SBINIT out of reset); 2 -> msgcode 0x95, subcode 0x01 (SBINIT done req); 3 -> msgcode 0x9A, subcode 0x01 (SBINIT done resp).
REQ-017 Packet layout SHALL be: [4:0] opcode 5'b10010; [21:14] msgcode; [39:32] subcode; [62] CP; [63] DP=0; all other bits 0.
REQ-018 Code 0 with valid SHALL be ignored silently; codes >3 with valid SHALL be ignored and pulse o_err_unsupported for one cycle; o_busy SHALL stay 0 in both cases.
REQ-019 PKT SHALL shift exactly 64 bits, bit 0 in the first PKT cycle, with o_sb_clk_en=1, then enter GAP.
REQ-020 GAP SHALL drive o_sb_data=0 and o_sb_clk_en=0 for GAP_UI cycles, then return to IDLE.
REQ-021 o_busy SHALL be 1 in every PKT, GAP, and PATTERN cycle and 0 in IDLE and PAT_HOLD.
REQ-022 In IDLE with i_start_pattern_req=1 and no valid message, SHALL enter PATTERN and output alternating 1,0 starting with 1 for 64*PATTERN_ITER cycles with o_sb_clk_en=1.
REQ-023 After PATTERN, SHALL enter PAT_HOLD with o_start_pattern_done=1 until i_start_pattern_req=0, then return to IDLE with done=0 next cycle; no pattern restart while the request stays high.
REQ-024 i_msg_valid during PKT, GAP, or PATTERN SHALL be ignored (not queued); in PAT_HOLD it SHALL be accepted as in IDLE, with done dropping to 0.
REQ-025 Deasserting i_start_pattern_req mid-PATTERN SHALL NOT abort; the pattern SHALL complete and then pass through PAT_HOLD for one cycle.
REQ-026 UI counter SHALL be 7 bits wide plus an iteration counter; wrap-around SHALL never occur within a state.

Reset
REQ-027 On i_rst_n=0, asynchronously: state=IDLE; o_busy, o_sb_data, o_sb_clk_en, o_start_pattern_done, and o_err_unsupported=0; shift register and counters=0.
REQ-028 Reset mid-packet or mid-pattern SHALL abort immediately with no residual bits after release.

Configuration
REQ-029 Macro SB_TX_PARITY_EN: when defined, CP SHALL equal the XOR of packet bits [61:0] (even parity); when undefined, CP SHALL be 0 and no parity logic SHALL be synthesised.

Verification
REQ-030 Code 1 valid for one cycle in IDLE -> o_busy high for 96 cycles; serial bits 0..4 = 0,1,0,0,1; bits 14..21 = 0x91 LSB first; busy falls after 32 low UI.
REQ-031 Pattern request held with PATTERN_ITER=2 -> 128 cycles of 1,0,1,0...; done=1 until request drops; done=0 one cycle later.
REQ-032 Code 2 and pattern request in the same IDLE cycle -> packet sent first; pattern starts after GAP if the request is still high.
REQ-033 Code 7 valid -> o_err_unsupported pulse of one cycle; o_busy=0; o_sb_clk_en=0.
REQ-034 Code 3 with SB_TX_PARITY_EN defined -> bit 62 = 1 (odd count in [61:0]); undefined -> bit 62 = 0.
REQ-035 i_rst_n low at PKT bit 30 -> all outputs 0 immediately; after release, IDLE with no further clk_en.

Source files
------------

// File: rtl/sb_msg_tx_engine.sv
// Sideband message transmitter: serialises 64-bit LTSM packets and the 64-UI clock pattern.
// Optional build macro SB_TX_PARITY_EN fills the CP bit with even parity over bits [61:0].
module sb_msg_tx_engine #(
  parameter int SB_MSG_WIDTH = 4,
  parameter int GAP_UI       = 32,
  parameter int PATTERN_ITER = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start_pattern_req,
  input  logic [SB_MSG_WIDTH-1:0] i_encoded_msg,
  input  logic                    i_msg_valid,
  output logic                    o_start_pattern_done,
  output logic                    o_busy,
  output logic                    o_sb_data,
  output logic                    o_sb_clk_en,
  output logic                    o_err_unsupported
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PATTERN  = 3'd1,
    PKT      = 3'd2,
    GAP      = 3'd3,
    PAT_HOLD = 3'd4
  } state_e;

  localparam int ITER_W = (PATTERN_ITER > 1) ? $clog2(PATTERN_ITER) : 1;

  localparam logic [6:0]        PKT_LAST  = 7'd63;
  localparam logic [6:0]        PAT_LAST  = 7'd63;
  localparam logic [6:0]        GAP_LAST  = 7'(GAP_UI - 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(PATTERN_ITER - 1);

  localparam logic [SB_MSG_WIDTH-1:0] CODE_1 = SB_MSG_WIDTH'(1);
  localparam logic [SB_MSG_WIDTH-1:0] CODE_2 = SB_MSG_WIDTH'(2);
  localparam logic [SB_MSG_WIDTH-1:0] CODE_3 = SB_MSG_WIDTH'(3);

  state_e              state_q, state_d;
  logic [6:0]          ui_cnt_q, ui_cnt_d;
  logic [ITER_W-1:0]   iter_cnt_q, iter_cnt_d;
  logic [63:0]         shift_q, shift_d;
  logic                err_q, err_d;

  logic [7:0] msg_code;
  logic [7:0] sub_code;
  logic       code_ok;
  logic       code_bad;
  logic       can_accept;
  logic       accept;
  logic       reject;

  function automatic logic [63:0] build_pkt(input logic [7:0] msgcode,
                                            input logic [7:0] subcode);
    logic [63:0] pkt;
    pkt        = '0;
    pkt[4:0]   = 5'b10010;
    pkt[21:14] = msgcode;
    pkt[39:32] = subcode;
`ifdef SB_TX_PARITY_EN
    pkt[62]    = ^pkt[61:0];
`endif
    return pkt;
  endfunction

  // Message decode; code 0 is neither supported nor an error.
  always_comb begin
    msg_code = 8'h00;
    sub_code = 8'h00;
    code_ok  = 1'b0;
    case (i_encoded_msg)
      CODE_1: begin msg_code = 8'h91; sub_code = 8'h00; code_ok = 1'b1; end
      CODE_2: begin msg_code = 8'h95; sub_code = 8'h01; code_ok = 1'b1; end
      CODE_3: begin msg_code = 8'h9A; sub_code = 8'h01; code_ok = 1'b1; end
      default: ;
    endcase
  end

  assign code_bad   = (i_encoded_msg > CODE_3);
  assign can_accept = (state_q == IDLE) || (state_q == PAT_HOLD);
  assign accept     = can_accept && i_msg_valid && code_ok;
  assign reject     = can_accept && i_msg_valid && code_bad;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = PKT;
        end else if (i_start_pattern_req && !i_msg_valid) begin
          state_d = PATTERN;
        end
      end
      PATTERN: begin
        if ((ui_cnt_q == PAT_LAST) && (iter_cnt_q == ITER_LAST)) begin
          state_d = PAT_HOLD;
        end
      end
      PKT: begin
        if (ui_cnt_q == PKT_LAST) begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (ui_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end
      end
      PAT_HOLD: begin
        if (accept) begin
          state_d = PKT;
        end else if (!i_start_pattern_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from state so reset clears them without waiting for a clock.
  always_comb begin
    o_busy               = 1'b0;
    o_sb_data            = 1'b0;
    o_sb_clk_en          = 1'b0;
    o_start_pattern_done = 1'b0;
    o_err_unsupported    = err_q;
    case (state_q)
      PATTERN: begin
        o_busy      = 1'b1;
        o_sb_clk_en = 1'b1;
        o_sb_data   = ~ui_cnt_q[0];
      end
      PKT: begin
        o_busy      = 1'b1;
        o_sb_clk_en = 1'b1;
        o_sb_data   = shift_q[0];
      end
      GAP: begin
        o_busy = 1'b1;
      end
      PAT_HOLD: begin
        o_start_pattern_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Counters restart on every state change, so no counter ever wraps inside a state.
  always_comb begin
    ui_cnt_d   = ui_cnt_q;
    iter_cnt_d = iter_cnt_q;
    shift_d    = shift_q;
    err_d      = reject;
    if (state_d != state_q) begin
      ui_cnt_d   = '0;
      iter_cnt_d = '0;
    end else begin
      case (state_q)
        PKT, GAP: begin
          ui_cnt_d = ui_cnt_q + 7'd1;
        end
        PATTERN: begin
          if (ui_cnt_q == PAT_LAST) begin
            ui_cnt_d   = '0;
            iter_cnt_d = iter_cnt_q + ITER_W'(1);
          end else begin
            ui_cnt_d = ui_cnt_q + 7'd1;
          end
        end
        default: begin
          ui_cnt_d   = '0;
          iter_cnt_d = '0;
        end
      endcase
    end
    if (state_q == PKT) begin
      shift_d = {1'b0, shift_q[63:1]};
    end
    if (accept) begin
      shift_d = build_pkt(msg_code, sub_code);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ui_cnt_q   <= '0;
      iter_cnt_q <= '0;
      shift_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      ui_cnt_q   <= ui_cnt_d;
      iter_cnt_q <= iter_cnt_d;
      shift_q    <= shift_d;
      err_q      <= err_d;
    end
  end

endmodule
